// File: rtl/match_pkg.sv
// Shared constants, converter state type and glyph lookup for the matchstick display stage.
package match_pkg;

  localparam int unsigned RefreshDivDefault = 50000;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_r     = 7'h50;
  localparam logic [6:0] SEG_n     = 7'h54;
  localparam logic [6:0] SEG_d     = 7'h5E;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, result and overflow flag latched together in DONE.
module bin2bcd_seq
  import match_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd,
  output logic             ovf
);

  // Enough nibbles for the full input range; only the low three are exported.
  localparam int unsigned Digits = (Width + 2) / 3;
  localparam int unsigned ScrW   = 4 * Digits;
  localparam int unsigned CntW   = $clog2(Width);

  conv_state_e       state_q, state_d;
  logic [Width-1:0]  sr_q, sr_d;
  logic [Width-1:0]  last_q, last_d;
  logic [ScrW-1:0]   scr_q, scr_d, scr_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < int'(Digits); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    last_d  = last_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          last_d  = bin;
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {scr_d, sr_d} = {scr_adj, sr_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CntW'(Width - 1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = scr_q[11:0];
        ovf_d   = (last_q > Width'(999));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      last_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/match_display.sv
// Matchstick game display: converts the stick count, picks the message and scans four digits.
module match_display
  import match_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = RefreshDivDefault,
  parameter int unsigned CONV_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CONV_BITS-1:0] datain,
  input  logic                 user,
  input  logic                 wrong,
  input  logic                 finish,
  output logic [6:0]           display,
  output logic [3:0]           grounds
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [CONV_BITS-1:0] last_q, last_d;
  logic                 valid_q, valid_d;
  logic [6:0]           display_q, display_d;
  logic [3:0]           grounds_q, grounds_d;

  logic        start, busy, done, ovf;
  logic [11:0] bcd;
  logic [3:0]  hun, ten, one;
  logic [6:0]  p_seg;
  logic [3:0][6:0] digs;

  // Restart whenever idle and the shown value is missing or stale.
  assign start = !busy && (!valid_q || (datain != last_q));

  bin2bcd_seq #(
    .Width(CONV_BITS)
  ) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .bin  (datain),
    .start(start),
    .busy (busy),
    .done (done),
    .bcd  (bcd),
    .ovf  (ovf)
  );

  assign hun   = bcd[11:8];
  assign ten   = bcd[7:4];
  assign one   = bcd[3:0];
  assign p_seg = user ? SEG_2 : SEG_1;

  always_comb begin
    digs = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    if (finish) begin
      digs = {SEG_E, SEG_n, SEG_d, p_seg};
    end else if (wrong) begin
      digs = {SEG_E, SEG_r, SEG_r, p_seg};
    end else begin
      digs[3] = p_seg;
      if (!valid_q) begin
        digs[2:0] = {SEG_BLANK, SEG_BLANK, SEG_BLANK};
      end else if (ovf) begin
        digs[2:0] = {SEG_DASH, SEG_DASH, SEG_DASH};
      end else begin
        digs[2] = (hun == 4'd0) ? SEG_BLANK : seg_digit(hun);
        digs[1] = ((hun == 4'd0) && (ten == 4'd0)) ? SEG_BLANK : seg_digit(ten);
        digs[0] = seg_digit(one);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    last_d    = start ? datain : last_q;
    valid_d   = valid_q | done;
    // Index 0 drives the leftmost digit (d3, grounds bit 3).
    display_d = digs[~idx_q];
    grounds_d = ~(4'b1000 >> idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      last_q    <= '0;
      valid_q   <= 1'b0;
      display_q <= 7'h00;
      grounds_q <= 4'hF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      display_q <= display_d;
      grounds_q <= grounds_d;
    end
  end

  assign display = display_q;
  assign grounds = grounds_q;

endmodule

// File: tb/tb_match_display.sv
// Scoreboard bench for match_display: expected scans queued from a decimal model, popped per slot.
module tb_match_display;

  localparam int unsigned Div = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] datain;
  logic        user, wrong, finish;
  logic [6:0]  display;
  logic [3:0]  grounds;

  int errs   = 0;
  int checks = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  match_display #(
    .REFRESH_DIV(Div),
    .CONV_BITS  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .datain (datain),
    .user   (user),
    .wrong  (wrong),
    .finish (finish),
    .display(display),
    .grounds(grounds)
  );

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got grounds=%b seg=%h, expected grounds=%b seg=%h",
               tag, got[10:7], got[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] msg_num(input int v, input logic usr);
    logic [6:0] p, gh, gt;
    int h, t;
    p = usr ? 7'h5B : 7'h06;
    if (v > 999) return {p, 7'h40, 7'h40, 7'h40};
    h  = v / 100;
    t  = (v / 10) % 10;
    gh = (h == 0) ? 7'h00 : glyph(h);
    gt = (h == 0 && t == 0) ? 7'h00 : glyph(t);
    return {p, gh, gt, glyph(v % 10)};
  endfunction

  function automatic logic [27:0] msg_err(input logic usr);
    return {7'h79, 7'h50, 7'h50, (usr ? 7'h5B : 7'h06)};
  endfunction

  function automatic logic [27:0] msg_end(input logic usr);
    return {7'h79, 7'h54, 7'h5E, (usr ? 7'h5B : 7'h06)};
  endfunction

  // Queue one full scan, align on the leftmost slot, then pop one entry per slot.
  task automatic scan_check(input string tag, input logic [27:0] msg);
    int guard;
    sb_q.push_back({4'b0111, msg[27:21]});
    sb_q.push_back({4'b1011, msg[20:14]});
    sb_q.push_back({4'b1101, msg[13:7]});
    sb_q.push_back({4'b1110, msg[6:0]});
    guard = 0;
    while (grounds !== 4'b0111 && guard < 5 * Div) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_slot%0d", tag, k), {grounds, display}, sb_q.pop_front());
      if (k < 3) wait_cycles(Div);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    datain = 16'd100;
    user   = 1'b0;
    wrong  = 1'b0;
    finish = 1'b0;
    wait_cycles(3);
    check_eq("reset_outputs", {grounds, display}, {4'hF, 7'h00});
    rst_n = 1'b1;
    wait_cycles(25);
    scan_check("show100", msg_num(100, 1'b0));

    datain = 16'd7;
    wait_cycles(25);
    scan_check("show7", msg_num(7, 1'b0));
    datain = 16'd0;
    wait_cycles(25);
    scan_check("show0", msg_num(0, 1'b0));

    // Change the value mid-conversion; the later value must win.
    datain = 16'd7;
    wait_cycles(6);
    datain = 16'd93;
    wait_cycles(45);
    scan_check("show93", msg_num(93, 1'b0));

    wrong = 1'b1;
    user  = 1'b1;
    wait_cycles(Div);
    scan_check("err2", msg_err(1'b1));
    wrong = 1'b0;
    wait_cycles(Div);
    scan_check("back2", msg_num(93, 1'b1));

    finish = 1'b1;
    wrong  = 1'b1;
    user   = 1'b0;
    wait_cycles(Div);
    scan_check("end1", msg_end(1'b0));
    finish = 1'b0;
    wrong  = 1'b0;

    datain = 16'd1234;
    wait_cycles(25);
    scan_check("ovf", msg_num(1234, 1'b0));
    datain = 16'd999;
    wait_cycles(25);
    scan_check("show999", msg_num(999, 1'b0));

    // Asynchronous reset in the middle of a conversion.
    datain = 16'd500;
    wait_cycles(5);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", {grounds, display}, {4'hF, 7'h00});
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(25);
    scan_check("show500", msg_num(500, 1'b0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
